// File: rtl/uart_byte_rx_if.sv
// Receive-side signal bundle of the byte UART: serial line in,
// received byte with valid/ready handshake and error pulses out.
interface uart_byte_rx_if;
    logic       rx;
    logic [7:0] data;
    logic       data_valid;
    logic       data_ready;
    logic       frame_err;
    logic       overrun;

    // Receiver side: samples the line, produces bytes and error pulses
    modport master (
        input  rx,
        input  data_ready,
        output data,
        output data_valid,
        output frame_err,
        output overrun
    );

    // Line driver / byte consumer side
    modport slave (
        output rx,
        output data_ready,
        input  data,
        input  data_valid,
        input  frame_err,
        input  overrun
    );
endinterface

// File: rtl/uart_byte_rx.sv
// 8N1 UART byte receiver with 16x oversampling, a one-deep output
// register with valid/ready handshake, frame-error and overrun pulses.
module uart_byte_rx #(
    parameter int DIV = 54
) (
    input  logic           clk,
    input  logic           rst,
    uart_byte_rx_if.master bus
);
    localparam int            CW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] DATA      = 3'd2;
    localparam logic [2:0] STOP      = 3'd3;
    localparam logic [2:0] WAIT_HIGH = 3'd4;

    logic          rx_m;
    logic          rx_s;
    logic [CW-1:0] cnt;
    logic          tick;
    logic [2:0]    state;
    logic [3:0]    smp;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic [7:0]    data_r;
    logic          data_valid_r;
    logic          frame_err_r;
    logic          overrun_r;
    logic          byte_done;
    logic          stop_bad;
    logic          handshake;

    assign tick      = (cnt == CNT_MAX);
    assign byte_done = tick && (state == STOP) && (smp == 4'd15) && rx_s;
    assign stop_bad  = tick && (state == STOP) && (smp == 4'd15) && !rx_s;
    assign handshake = data_valid_r && bus.data_ready;

    assign bus.data       = data_r;
    assign bus.data_valid = data_valid_r;
    assign bus.frame_err  = frame_err_r;
    assign bus.overrun    = overrun_r;

    // Two-flop synchronizer on the asynchronous line; resets to the idle level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= bus.rx;
            rx_s <= rx_m;
        end
    end

    // Free-running oversample tick divider, independent of frame state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
        end
    end

    // Frame FSM: start qualification at mid start bit, mid-bit data sampling, stop check
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            smp     <= 4'd0;
            bit_idx <= 3'd0;
            shreg   <= 8'h00;
        end else if (tick) begin
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        smp   <= 4'd0;
                    end
                end
                START: begin
                    if (smp == 4'd7) begin
                        if (!rx_s) begin
                            state   <= DATA;
                            smp     <= 4'd0;
                            bit_idx <= 3'd0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        smp <= smp + 4'd1;
                    end
                end
                DATA: begin
                    if (smp == 4'd15) begin
                        shreg <= {rx_s, shreg[7:1]};
                        smp   <= 4'd0;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        smp <= smp + 4'd1;
                    end
                end
                STOP: begin
                    if (smp == 4'd15) begin
                        smp   <= 4'd0;
                        state <= rx_s ? IDLE : WAIT_HIGH;
                    end else begin
                        smp <= smp + 4'd1;
                    end
                end
                WAIT_HIGH: begin
                    // A held-low break line parks here so it reports only one frame error
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Output register: load on completion unless still holding an unaccepted byte
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_r       <= 8'h00;
            data_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
            overrun_r    <= 1'b0;
        end else begin
            frame_err_r <= stop_bad;
            overrun_r   <= byte_done && data_valid_r && !bus.data_ready;
            if (byte_done) begin
                if (!data_valid_r || bus.data_ready) begin
                    data_r       <= shreg;
                    data_valid_r <= 1'b1;
                end
            end else if (handshake) begin
                data_valid_r <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_byte_rx.sv
// Scoreboard bench for uart_byte_rx: expected bytes are queued as frames
// are driven and compared at each consumer handshake.
module tb_uart_byte_rx;
    localparam int DIV = 16;
    localparam int BIT = 16 * DIV;

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_byte_rx_if bus();

    uart_byte_rx #(.DIV(DIV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;

    logic [7:0] sbq[$];
    logic [7:0] exp_b;

    int   dv_rise = 0, dv_fall = 0, dv_hi = 0;
    int   fe_cnt = 0, ov_cnt = 0, fe_long = 0, ov_long = 0;
    logic dv_q = 1'b0, fe_q = 1'b0, ov_q = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then step off the edge before driving/sampling
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        bus.rx = 1'b0;
        cyc(BIT);
        for (int i = 0; i < 8; i++) begin
            bus.rx = b[i];
            cyc(BIT);
        end
        bus.rx = stop;
        cyc(BIT);
        bus.rx = 1'b1;
    endtask

    // Monitor on the falling edge: event counters and handshake scoreboard
    always @(negedge clk) begin
        if (bus.data_valid && !dv_q) dv_rise++;
        if (!bus.data_valid && dv_q) dv_fall++;
        if (bus.data_valid) dv_hi++;
        if (bus.frame_err) fe_cnt++;
        if (bus.frame_err && fe_q) fe_long++;
        if (bus.overrun) ov_cnt++;
        if (bus.overrun && ov_q) ov_long++;
        if (bus.data_valid && bus.data_ready) begin
            if (sbq.size() == 0) begin
                chk("sb_pending", 32'(sbq.size()), 32'd1);
            end else begin
                exp_b = sbq.pop_front();
                chk("sb_data", 32'(bus.data), 32'(exp_b));
            end
        end
        dv_q = bus.data_valid;
        fe_q = bus.frame_err;
        ov_q = bus.overrun;
    end

    int   r0, h0, f0, o0, d0;
    logic found;
    logic [7:0] b55;

    initial begin
        bus.rx         = 1'b1;
        bus.data_ready = 1'b0;
        found          = 1'b0;
        b55            = 8'h55;
        cyc(5);
        chk("rst_data", 32'(bus.data), 32'h00);
        chk("rst_dv",   32'(bus.data_valid), 32'd0);
        chk("rst_fe",   32'(bus.frame_err), 32'd0);
        chk("rst_ov",   32'(bus.overrun), 32'd0);
        rst = 1'b0;
        cyc(BIT);

        // Single byte with consumer always ready
        bus.data_ready = 1'b1;
        r0 = dv_rise; h0 = dv_hi; f0 = fe_cnt; o0 = ov_cnt;
        sbq.push_back(8'h70);
        send_byte(8'h70, 1'b1);
        cyc(BIT);
        chk("t1_rise", 32'(dv_rise - r0), 32'd1);
        chk("t1_hi",   32'(dv_hi - h0), 32'd1);
        chk("t1_fe",   32'(fe_cnt - f0), 32'd0);
        chk("t1_ov",   32'(ov_cnt - o0), 32'd0);
        chk("t1_sb",   32'(sbq.size()), 32'd0);

        // Back-to-back bytes with consumer stalled: second byte dropped
        bus.data_ready = 1'b0;
        r0 = dv_rise; o0 = ov_cnt;
        sbq.push_back(8'h31);
        send_byte(8'h31, 1'b1);
        send_byte(8'h32, 1'b1);
        cyc(BIT);
        chk("t2_data", 32'(bus.data), 32'h31);
        chk("t2_dv",   32'(bus.data_valid), 32'd1);
        chk("t2_ov",   32'(ov_cnt - o0), 32'd1);
        chk("t2_rise", 32'(dv_rise - r0), 32'd1);
        bus.data_ready = 1'b1;
        cyc(1);
        chk("t2_dv_clr", 32'(bus.data_valid), 32'd0);
        chk("t2_hold",   32'(bus.data), 32'h31);
        chk("t2_sb",     32'(sbq.size()), 32'd0);

        // Short low glitch shorter than half a bit
        r0 = dv_rise; f0 = fe_cnt;
        bus.rx = 1'b0;
        cyc(5 * DIV);
        bus.rx = 1'b1;
        cyc(2 * BIT);
        chk("t3_rise",  32'(dv_rise - r0), 32'd0);
        chk("t3_fe",    32'(fe_cnt - f0), 32'd0);
        chk("t3_state", 32'(dut.state), 32'd0);

        // Stop bit low followed by a long break, then a clean byte
        r0 = dv_rise; f0 = fe_cnt;
        send_byte(8'h33, 1'b0);
        bus.rx = 1'b0;
        cyc(5000);
        bus.rx = 1'b1;
        cyc(BIT);
        chk("t4_fe",   32'(fe_cnt - f0), 32'd1);
        chk("t4_rise", 32'(dv_rise - r0), 32'd0);
        r0 = dv_rise;
        sbq.push_back(8'h33);
        send_byte(8'h33, 1'b1);
        cyc(BIT);
        chk("t4_rise2", 32'(dv_rise - r0), 32'd1);
        chk("t4_data",  32'(bus.data), 32'h33);
        chk("t4_sb",    32'(sbq.size()), 32'd0);

        // Reset in the middle of a 0x55 frame; the leftover low bit 7 then
        // reads as a start bit followed by idle-high data, i.e. a valid 0xFF
        bus.rx = 1'b0;
        cyc(BIT);
        for (int i = 0; i < 6; i++) begin
            bus.rx = b55[i];
            cyc(BIT);
        end
        bus.rx = b55[6];
        cyc(BIT / 2);
        rst = 1'b1;
        #1;
        chk("t5_data", 32'(bus.data), 32'h00);
        chk("t5_dv",   32'(bus.data_valid), 32'd0);
        chk("t5_fe",   32'(bus.frame_err), 32'd0);
        chk("t5_ov",   32'(bus.overrun), 32'd0);
        cyc(10);
        rst = 1'b0;
        r0 = dv_rise;
        cyc(BIT / 2);
        sbq.push_back(8'hFF);
        bus.rx = b55[7];
        cyc(BIT);
        bus.rx = 1'b1;
        cyc(12 * BIT);
        chk("t5_rise", 32'(dv_rise - r0), 32'd1);
        chk("t5_sb",   32'(sbq.size()), 32'd0);
        sbq.push_back(8'hAA);
        send_byte(8'hAA, 1'b1);
        cyc(BIT);
        chk("t5_aa", 32'(bus.data), 32'hAA);
        chk("t5_sb2", 32'(sbq.size()), 32'd0);

        // Byte completion in the exact cycle the previous byte is accepted
        bus.data_ready = 1'b0;
        sbq.push_back(8'h33);
        send_byte(8'h33, 1'b1);
        chk("t6_dv0", 32'(bus.data_valid), 32'd1);
        d0 = dv_fall; o0 = ov_cnt;
        sbq.push_back(8'h34);
        found = 1'b0;
        fork
            send_byte(8'h34, 1'b1);
            begin
                for (int i = 0; i < 12 * BIT && !found; i++) begin
                    cyc(1);
                    if (dut.byte_done) begin
                        bus.data_ready = 1'b1;
                        found = 1'b1;
                    end
                end
                if (found) begin
                    cyc(1);
                    bus.data_ready = 1'b0;
                end
            end
        join
        cyc(4);
        chk("t6_sync", 32'(found), 32'd1);
        chk("t6_data", 32'(bus.data), 32'h34);
        chk("t6_dv",   32'(bus.data_valid), 32'd1);
        chk("t6_fall", 32'(dv_fall - d0), 32'd0);
        chk("t6_ov",   32'(ov_cnt - o0), 32'd0);
        bus.data_ready = 1'b1;
        cyc(2);
        chk("t6_dv_clr", 32'(bus.data_valid), 32'd0);
        chk("t6_sb",     32'(sbq.size()), 32'd0);

        chk("fe_width", 32'(fe_long), 32'd0);
        chk("ov_width", 32'(ov_long), 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
